wptr_full: RTL
==============

# wptr_full

Write-domain pointer and full-flag generator for the asynchronous FIFO. It keeps the write pointer in binary and Gray code and supplies the write address to the dual-port memory. It compares the next write pointer against the read pointer that has already been synchronised into the write domain, and produces registered `wfull`, `walmost_full`, a fill count and a sticky overflow flag. It sits downstream of the read-to-write pointer synchroniser and upstream of the memory write port.

## Interface
- `ADDRSIZE`, 8, memory address width; depth = 2^ADDRSIZE; legal range ≥ 2
- `AFULL_MARGIN`, 2, `walmost_full` asserts when free slots ≤ this value; legal range 1 .. 2^ADDRSIZE-1
- `wclk` input 1: write clock; the only clock in this block
- `wrst_n` input 1: reset; asynchronous and active-low
- `winc` input 1: write request for this cycle
- `wq2_rptr` input ADDRSIZE+1: read pointer in Gray code, already double-synchronised into `wclk`
- `wovf_clr` input 1: clears `woverflow`
- `waddr` output ADDRSIZE: memory write address, equal to `wbin[ADDRSIZE-1:0]`
- `wptr` output ADDRSIZE+1: registered Gray write pointer, sent to the write-to-read synchroniser
- `wfull` output 1: registered full flag
- `walmost_full` output 1: registered almost-full flag
- `wcount` output ADDRSIZE+1: registered fill level, range 0 .. 2^ADDRSIZE
- `woverflow` output 1: sticky flag, set when a write is attempted while full

## Operation
- Internal binary pointer `wbin`, ADDRSIZE+1 bits.
- `wbinnext = wbin + (winc & ~wfull)`, modulo 2^(ADDRSIZE+1).
- `wgraynext = (wbinnext >> 1) ^ wbinnext`.
- On each `wclk` edge: `wbin <= wbinnext` and `wptr <= wgraynext`.
- A write is accepted only when `winc & ~wfull`. A blocked write does not advance the pointer and the memory must not be written.
- Full test: `wfull <= (wgraynext == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]})`, where A = ADDRSIZE.
- Read pointer conversion: `rbin_s = gray2bin(wq2_rptr)` (XOR prefix from the MSB down), combinational.
- `wcount <= wbinnext - rbin_s`, modulo 2^(ADDRSIZE+1).
- `walmost_full <= (wbinnext - rbin_s) >= 2^A - AFULL_MARGIN`.
- `woverflow` is set when `winc & wfull`, cleared by `wovf_clr`, and otherwise holds. Set has priority over a simultaneous clear.
- No state machine. State consists of the pointer registers plus the flag registers.
- Wrap-around: the MSB of `wbin` toggles on every pass through the address space, which lets full be distinguished from empty. `waddr` wraps from 2^A-1 to 0.

## Timing
- Reset values, applied asynchronously while `wrst_n` = 0: `wbin`, `wptr`, `waddr`, `wcount` = 0; `wfull`, `walmost_full`, `woverflow` = 0.
- After `wrst_n` deasserts, outputs update on the first `wclk` rising edge.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- `wfull` asserts on the same edge that accepts the 2^A-th outstanding write. There are no dead cycles.
- `wfull` deasserts one `wclk` after `wq2_rptr` advances. The release is pessimistic by the synchroniser delay; this is intended and safe.
- `waddr` is valid in the same cycle that `winc` is sampled. The memory writes at `waddr` on that edge.
- `wptr` changes by exactly one bit per accepted write.
- Simultaneous write and read advance: `wcount` is unchanged and `wfull` is recomputed from both updated pointers.

## Structure
- Shared package `fifo_pkg` holds:
  - function `bin2gray(logic [ADDRSIZE:0])`
  - function `gray2bin(logic [ADDRSIZE:0])`
  - a localparam convention `DEPTH = 1 << ADDRSIZE`
- The read-domain twin block uses the same functions from this package.
- One sub-module is natural: `fifo_gray2bin`, a parameterised combinational converter used for `rbin_s`.
- All registers live in a single `always_ff @(posedge wclk or negedge wrst_n)` block.

## Test plan
All scenarios use ADDRSIZE=8 and AFULL_MARGIN=2.
- **Reset:** `wrst_n` low mid-stream after 10 writes → all outputs 0 immediately; the first write after release has `waddr` = 0 and gives `wptr` = 9'h001.
- **Fill:** `wq2_rptr` = 0, 256 consecutive `winc` → `wfull` = 1 on the edge of write 256; `wcount` = 256; `wptr` = 9'h180.
- **Almost-full:** under the fill scenario, `walmost_full` rises on the edge of write 254 (`wcount` = 254) and stays high while full.
- **Overflow:**
  - While full, `winc` = 1 for 3 cycles → `wbin` and `waddr` are unchanged and `woverflow` = 1.
  - `wovf_clr` pulsed with `winc` = 0 → `woverflow` = 0.
  - `wovf_clr` and `winc` together while full → `woverflow` stays 1.
- **Release and wrap:**
  - From full, step `wq2_rptr` to 9'h001 → `wfull` = 0 one cycle later and `wcount` = 255.
  - Continue 512 total writes with `rptr` tracking → `waddr` wraps 255→0.
  - The MSB of `wbin` toggles, and every `wptr` step has Hamming distance 1.
- **Concurrent write and read:** `winc` held high while `wq2_rptr` advances by one each cycle at `wcount` = 100 → `wcount` stays 100 and `wfull`/`walmost_full` stay 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the asynchronous FIFO write- and read-domain blocks.
// Conversions operate on a wide zero-extended vector so any pointer width up to PTR_MAX_W can use them.
package fifo_pkg;

    localparam int DEF_ADDRSIZE = 8;
    localparam int PTR_MAX_W    = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Leading zeros of a zero-extended input leave the low bits of the result unchanged.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Parameterised combinational Gray-to-binary converter for synchronised FIFO pointers.
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int W = DEF_ADDRSIZE + 1
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = W'(gray2bin(ptr_t'(gray)));
    end

endmodule

// File: rtl/wptr_full.sv
// Write-domain pointer and full/almost-full/fill-level/overflow generator for the async FIFO.
// Flags are computed from the next write pointer so wfull asserts on the edge of the last accepted write.
module wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = DEF_ADDRSIZE,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wcount,
    output logic                woverflow
);

    localparam int PTR_W = ADDRSIZE + 1;
    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [PTR_W-1:0] AFULL_LEVEL = PTR_W'(DEPTH - AFULL_MARGIN);

    logic [PTR_W-1:0] wbin_q, wbin_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] wcount_q, wcount_d;
    logic             wfull_q, wfull_d;
    logic             walmost_full_q, walmost_full_d;
    logic             woverflow_q, woverflow_d;

    logic [PTR_W-1:0] rbin_s;
    logic [PTR_W-1:0] fill_next;
    logic [PTR_W-1:0] full_pattern;
    logic             wr_accept;

    fifo_gray2bin #(
        .W(PTR_W)
    ) u_rptr_g2b (
        .gray(wq2_rptr),
        .bin (rbin_s)
    );

    // Full when the next Gray pointer equals the read pointer with its top two bits inverted.
    always_comb begin
        wr_accept      = winc & ~wfull_q;
        wbin_d         = wbin_q + PTR_W'(wr_accept);
        wptr_d         = PTR_W'(bin2gray(ptr_t'(wbin_d)));
        full_pattern   = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
        wfull_d        = (wptr_d == full_pattern);
        fill_next      = wbin_d - rbin_s;
        wcount_d       = fill_next;
        walmost_full_d = (fill_next >= AFULL_LEVEL);
        woverflow_d    = woverflow_q;
        if (wovf_clr) begin
            woverflow_d = 1'b0;
        end
        if (winc & wfull_q) begin
            woverflow_d = 1'b1;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wcount_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wcount_q       <= wcount_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign waddr        = wbin_q[ADDRSIZE-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wcount       = wcount_q;
    assign woverflow    = woverflow_q;

endmodule
